// File: rtl/tl_probe_sequencer.sv
// Turns one probe request into per-client TileLink B probes, collects C-channel acks, reports a summary.
// Probes issue back-to-back under b_ready_i; done is held until done_ready_i; the request port is closed while busy.
module tl_probe_sequencer #(
  parameter int NumClients    = 2,
  parameter int AddrWidth     = 56,
  parameter int ClientWidth   = (NumClients > 1) ? $clog2(NumClients) : 1,
  parameter int BeatsPerBlock = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_address_i,
  input  logic                   req_block_i,
  input  logic [2:0]             req_param_i,
  input  logic [NumClients-1:0]  req_mask_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [2:0]             b_opcode_o,
  output logic [2:0]             b_param_o,
  output logic [ClientWidth-1:0] b_source_o,
  output logic [AddrWidth-1:0]   b_address_o,
  input  logic                   c_valid_i,
  output logic                   c_ready_o,
  input  logic [2:0]             c_opcode_i,
  input  logic [2:0]             c_param_i,
  input  logic [ClientWidth-1:0] c_source_i,
  output logic                   done_valid_o,
  input  logic                   done_ready_i,
  output logic                   done_dirty_o,
  output logic                   done_had_t_o,
  output logic                   err_o
);

  localparam int CntWidth = (BeatsPerBlock > 1) ? $clog2(BeatsPerBlock) : 1;
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BeatsPerBlock - 1);

  typedef enum logic [1:0] {Idle, Issue, Collect, Done} state_e;

  state_e                 state;
  logic [AddrWidth-1:0]   addrQ;
  logic [2:0]             opcodeQ;
  logic [2:0]             paramQ;
  logic [NumClients-1:0]  issueMask;
  logic [NumClients-1:0]  pendMask;
  logic                   dirty;
  logic                   hadT;
  logic [CntWidth-1:0]    beatCnt;
  logic                   reqReadyQ;
  logic                   bValidQ;
  logic [ClientWidth-1:0] bSourceQ;
  logic                   cReadyQ;
  logic                   doneValidQ;
  logic                   doneDirtyQ;
  logic                   doneHadTQ;
  logic                   errQ;

  logic                   cFire;
  logic                   isData;
  logic                   lastBeat;
  logic                   ackGood;
  logic                   bFire;
  logic                   tFlag;
  logic [NumClients-1:0]  srcOneHot;
  logic [NumClients-1:0]  bOneHot;
  logic [NumClients-1:0]  issueNext;
  logic [NumClients-1:0]  pendNext;

  function automatic logic [ClientWidth-1:0] lowestIdx(input logic [NumClients-1:0] m);
    logic [ClientWidth-1:0] idx;
    idx = '0;
    for (int i = NumClients - 1; i >= 0; i--) begin
      if (m[i]) idx = ClientWidth'(i);
    end
    return idx;
  endfunction

  always_comb begin
    cFire     = c_valid_i & cReadyQ;
    isData    = (c_opcode_i == 3'd5);
    lastBeat  = !isData || (beatCnt == LastBeat);
    tFlag     = (c_param_i == 3'd0) || (c_param_i == 3'd1) || (c_param_i == 3'd3);
    srcOneHot = '0;
    bOneHot   = '0;
    for (int i = 0; i < NumClients; i++) begin
      if (c_source_i == ClientWidth'(i)) srcOneHot[i] = 1'b1;
      if (bSourceQ == ClientWidth'(i)) bOneHot[i] = 1'b1;
    end
    // An ack only counts for a client that was probed and has not answered yet.
    ackGood   = cFire && lastBeat && (|(srcOneHot & pendMask & ~issueMask));
    bFire     = bValidQ & b_ready_i;
    issueNext = bFire ? (issueMask & ~bOneHot) : issueMask;
    pendNext  = ackGood ? (pendMask & ~srcOneHot) : pendMask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= Idle;
      addrQ      <= '0;
      opcodeQ    <= '0;
      paramQ     <= '0;
      issueMask  <= '0;
      pendMask   <= '0;
      dirty      <= 1'b0;
      hadT       <= 1'b0;
      beatCnt    <= '0;
      reqReadyQ  <= 1'b0;
      bValidQ    <= 1'b0;
      bSourceQ   <= '0;
      cReadyQ    <= 1'b0;
      doneValidQ <= 1'b0;
      doneDirtyQ <= 1'b0;
      doneHadTQ  <= 1'b0;
      errQ       <= 1'b0;
    end else begin
      errQ      <= cFire && lastBeat && !ackGood;
      issueMask <= issueNext;
      pendMask  <= pendNext;
      if (cFire && isData) begin
        beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
      end
      if (ackGood) begin
        dirty <= dirty | isData;
        hadT  <= hadT | tFlag;
      end
      case (state)
        Idle: begin
          reqReadyQ <= 1'b1;
          if (reqReadyQ && req_valid_i) begin
            addrQ     <= req_address_i;
            opcodeQ   <= req_block_i ? 3'd6 : 3'd7;
            paramQ    <= req_param_i;
            issueMask <= req_mask_i;
            pendMask  <= req_mask_i;
            dirty     <= 1'b0;
            hadT      <= 1'b0;
            reqReadyQ <= 1'b0;
            if (|req_mask_i) begin
              state    <= Issue;
              bValidQ  <= 1'b1;
              bSourceQ <= lowestIdx(req_mask_i);
              cReadyQ  <= 1'b1;
            end else begin
              state      <= Done;
              doneValidQ <= 1'b1;
              doneDirtyQ <= 1'b0;
              doneHadTQ  <= 1'b0;
            end
          end
        end
        Issue: begin
          if (issueNext == '0) begin
            state   <= Collect;
            bValidQ <= 1'b0;
          end else begin
            bSourceQ <= lowestIdx(issueNext);
          end
        end
        Collect: begin
          // Registered pendMask: a final ack always costs one Collect cycle before Done.
          if (pendMask == '0) begin
            state      <= Done;
            cReadyQ    <= 1'b0;
            doneValidQ <= 1'b1;
            doneDirtyQ <= dirty;
            doneHadTQ  <= hadT;
          end
        end
        Done: begin
          if (done_ready_i) begin
            state      <= Idle;
            doneValidQ <= 1'b0;
            doneDirtyQ <= 1'b0;
            doneHadTQ  <= 1'b0;
            reqReadyQ  <= 1'b1;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

  assign req_ready_o  = reqReadyQ;
  assign b_valid_o    = bValidQ;
  assign b_opcode_o   = opcodeQ;
  assign b_param_o    = paramQ;
  assign b_source_o   = bSourceQ;
  assign b_address_o  = addrQ;
  assign c_ready_o    = cReadyQ;
  assign done_valid_o = doneValidQ;
  assign done_dirty_o = doneDirtyQ;
  assign done_had_t_o = doneHadTQ;
  assign err_o        = errQ;

endmodule
